reg_file: RTL

Architectural register file and read responder for the MyProc2 pipeline: it answers the ID stage's two read-request ports (`Rd*_addr`/`Rd*_en` in, `Rd*_data`/`Rd*_st` out) and accepts one writeback port. A per-register pending scoreboard holds a read that targets a register with an outstanding write until writeback delivers the value. It sits between ID and the WB stage.

---
 rtl/reg_file_pkg.sv | 15 +
 rtl/reg_file_rf_read_port.sv | 87 ++++++++
 rtl/reg_file.sv | 97 +++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared sizing constants and read-port FSM encoding for the
// architectural register file.
package reg_file_pkg;

    localparam int RF_WIDTH    = 32;
    localparam int RF_ADDR_LEN = 5;
    localparam logic [RF_WIDTH-1:0] RF_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        RF_IDLE = 2'd0,
        RF_WAIT = 2'd1,
        RF_DONE = 2'd2
    } rf_state_e;

endpackage

// File: rtl/reg_file_rf_read_port.sv
// One read responder: completes immediately on a ready register,
// otherwise parks on the latched address until writeback delivers it.
module rf_read_port
    import reg_file_pkg::*;
#(
    parameter int WIDTH        = RF_WIDTH,
    parameter int REG_ADDR_LEN = RF_ADDR_LEN,
    localparam int DEPTH       = 1 << REG_ADDR_LEN
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en,
    input  logic [REG_ADDR_LEN-1:0]            addr,
    input  logic [DEPTH-1:0][WIDTH-1:0]        regs,
    input  logic [DEPTH-1:0]                   pend,
    input  logic                               wr_en,
    input  logic [REG_ADDR_LEN-1:0]            wr_addr,
    input  logic [WIDTH-1:0]                   wr_data,
    output logic [WIDTH-1:0]                   data,
    output logic                               st
);

    rf_state_e               state_q, state_d;
    logic [REG_ADDR_LEN-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]        data_q, data_d;
    logic                    st_q, st_d;

    logic             fwd_hit;
    logic             tgt_pend;
    logic [WIDTH-1:0] tgt_val;
    logic             wait_hit;

    // A write in the same cycle forwards and masks the pending bit.
    assign fwd_hit  = wr_en && (wr_addr == addr);
    assign tgt_pend = (addr != '0) && pend[addr] && !fwd_hit;
    assign tgt_val  = (addr == '0) ? '0 :
                      fwd_hit      ? wr_data : regs[addr];
    assign wait_hit = wr_en && (wr_addr == addr_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        st_d    = 1'b0;
        unique case (state_q)
            RF_WAIT: begin
                if (!en) begin
                    state_d = RF_IDLE;
                end else if (wait_hit) begin
                    data_d  = wr_data;
                    st_d    = 1'b1;
                    state_d = RF_DONE;
                end
            end
            default: begin
                if (!en) begin
                    state_d = RF_IDLE;
                end else if (tgt_pend) begin
                    addr_d  = addr;
                    state_d = RF_WAIT;
                end else begin
                    data_d  = tgt_val;
                    st_d    = 1'b1;
                    state_d = RF_DONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            st_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            st_q    <= st_d;
        end
    end

    assign data = data_q;
    assign st   = st_q;

endmodule

// File: rtl/reg_file.sv
// Architectural register file with pending scoreboard and two
// blocking read responders for the ID stage.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH        = RF_WIDTH,
    parameter int REG_ADDR_LEN = RF_ADDR_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_ADDR_LEN-1:0] Rd1_addr,
    input  logic                    Rd1_en,
    output logic [WIDTH-1:0]        Rd1_data,
    output logic                    Rd1_st,
    input  logic [REG_ADDR_LEN-1:0] Rd2_addr,
    input  logic                    Rd2_en,
    output logic [WIDTH-1:0]        Rd2_data,
    output logic                    Rd2_st,
    input  logic [REG_ADDR_LEN-1:0] Wr_addr,
    input  logic [WIDTH-1:0]        Wr_data,
    input  logic                    Wr_en,
    input  logic [REG_ADDR_LEN-1:0] Rsv_addr,
    input  logic                    Rsv_en,
    output logic                    Pend_any
);

    localparam int DEPTH = 1 << REG_ADDR_LEN;

    logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]            pend_q, pend_d;
    logic                        pend_any_q, pend_any_d;

    // Reservation is applied after the write so it wins on a tie.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (Wr_en && Wr_addr != '0) begin
            regs_d[Wr_addr] = Wr_data;
            pend_d[Wr_addr] = 1'b0;
        end
        if (Rsv_en && Rsv_addr != '0) begin
            pend_d[Rsv_addr] = 1'b1;
        end
        regs_d[0]  = '0;
        pend_d[0]  = 1'b0;
        pend_any_d = |pend_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q     <= '0;
            pend_q     <= '0;
            pend_any_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            pend_any_q <= pend_any_d;
        end
    end

    assign Pend_any = pend_any_q;

    rf_read_port #(
        .WIDTH        (WIDTH),
        .REG_ADDR_LEN (REG_ADDR_LEN)
    ) u_rd1 (
        .clk     (clk),
        .rst     (rst),
        .en      (Rd1_en),
        .addr    (Rd1_addr),
        .regs    (regs_q),
        .pend    (pend_q),
        .wr_en   (Wr_en),
        .wr_addr (Wr_addr),
        .wr_data (Wr_data),
        .data    (Rd1_data),
        .st      (Rd1_st)
    );

    rf_read_port #(
        .WIDTH        (WIDTH),
        .REG_ADDR_LEN (REG_ADDR_LEN)
    ) u_rd2 (
        .clk     (clk),
        .rst     (rst),
        .en      (Rd2_en),
        .addr    (Rd2_addr),
        .regs    (regs_q),
        .pend    (pend_q),
        .wr_en   (Wr_en),
        .wr_addr (Wr_addr),
        .wr_data (Wr_data),
        .data    (Rd2_data),
        .st      (Rd2_st)
    );

endmodule
